// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: stall/flush per stage, load-use interlock, exception redirect,
// start/ready handshake FSM per multicycle unit, saturating hazard counters.
module hazard_ctrl_mc #(
  parameter int          NUM_MCU    = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E,
  parameter int          CNT_W      = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         ex_rt,
  input  logic               ex_rmem,
  input  logic [NUM_MCU-1:0] ex_mcu_req,
  input  logic [NUM_MCU-1:0] mcu_ready,
  output logic [NUM_MCU-1:0] mcu_start,
  output logic [NUM_MCU-1:0] mcu_cancel,
  input  logic               stallreq_from_if,
  input  logic               stallreq_from_mem,
  input  logic [31:0]        mem_excepttype,
  input  logic [31:0]        mem_cp0_epc,
  output logic [4:0]         stall,
  output logic [4:0]         flush,
  output logic [31:0]        mem_newpc,
  output logic               except_flush,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_lwstall,
  output logic [CNT_W-1:0]   cnt_mcustall,
  output logic [CNT_W-1:0]   cnt_except
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mcu_state_e;

  mcu_state_e         r_state [NUM_MCU];
  mcu_state_e         w_state_nxt [NUM_MCU];
  logic [NUM_MCU-1:0] w_start;
  logic [NUM_MCU-1:0] w_cancel;
  logic [NUM_MCU-1:0] w_mcu_busy;
  logic               w_lwstall;
  logic               w_exc_raw;
  logic               w_except_flush;
  logic               w_exc_hold;
  logic               w_mcu_stall;
  logic               w_stall_fe;
  logic               w_stall_ex;
  logic               w_ex_adv;
  logic               w_lw_cnt;
  logic [4:0]         w_stall_raw;
  logic [4:0]         w_flush;
  logic [CNT_W-1:0]   r_cnt_lw;
  logic [CNT_W-1:0]   r_cnt_mcu;
  logic [CNT_W-1:0]   r_cnt_exc;

  assign w_lwstall      = ex_rmem && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign w_exc_raw      = (mem_excepttype != 32'd0);
  // Redirect is deferred while either bus still has a transaction in flight.
  assign w_except_flush = w_exc_raw && !stallreq_from_if && !stallreq_from_mem;
  assign w_exc_hold     = w_exc_raw && !w_except_flush;
  assign w_mcu_stall    = |w_mcu_busy;

  assign w_stall_fe  = w_lwstall | w_mcu_stall | stallreq_from_if | stallreq_from_mem | w_exc_hold;
  assign w_stall_ex  = w_mcu_stall | stallreq_from_mem | w_exc_hold;
  assign w_stall_raw = {1'b0, w_stall_ex, w_stall_ex, w_stall_fe, w_stall_fe};
  assign w_flush     = {w_except_flush | stallreq_from_mem | w_exc_hold,
                        w_except_flush,
                        w_except_flush | (w_lwstall & ~w_stall_ex),
                        w_except_flush,
                        w_except_flush};
  assign w_ex_adv    = !w_stall_ex || w_except_flush;
  assign w_lw_cnt    = w_lwstall && !w_stall_ex;

  assign stall        = w_stall_raw & ~w_flush;
  assign flush        = w_flush;
  assign except_flush = w_except_flush;
  assign mem_newpc    = (mem_excepttype == ERET_CODE) ? mem_cp0_epc : EXC_VECTOR;
  // Pulses are suppressed while reset is held even though the FSMs sit in IDLE.
  assign mcu_start    = w_start & {NUM_MCU{resetn}};
  assign mcu_cancel   = w_cancel & {NUM_MCU{resetn}};

  always_comb begin
    w_start    = '0;
    w_cancel   = '0;
    w_mcu_busy = '0;
    for (int i = 0; i < NUM_MCU; i++) begin
      w_state_nxt[i] = r_state[i];
      w_mcu_busy[i]  = ex_mcu_req[i] && (r_state[i] != ST_DONE);
      case (r_state[i])
        ST_IDLE: begin
          if (ex_mcu_req[i] && !w_except_flush) begin
            w_start[i]     = 1'b1;
            w_state_nxt[i] = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_except_flush) begin
            w_cancel[i]    = 1'b1;
            w_state_nxt[i] = ST_IDLE;
          end else if (mcu_ready[i]) begin
            w_state_nxt[i] = ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_ex_adv) w_state_nxt[i] = ST_IDLE;
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_MCU; i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_MCU; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Counters saturate at all-ones; clear has priority over increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt_lw  <= '0;
      r_cnt_mcu <= '0;
      r_cnt_exc <= '0;
    end else if (cnt_clr) begin
      r_cnt_lw  <= '0;
      r_cnt_mcu <= '0;
      r_cnt_exc <= '0;
    end else begin
      if (w_lw_cnt && !(&r_cnt_lw))         r_cnt_lw  <= r_cnt_lw + CNT_W'(1);
      if (w_mcu_stall && !(&r_cnt_mcu))     r_cnt_mcu <= r_cnt_mcu + CNT_W'(1);
      if (w_except_flush && !(&r_cnt_exc))  r_cnt_exc <= r_cnt_exc + CNT_W'(1);
    end
  end

  assign cnt_lwstall  = r_cnt_lw;
  assign cnt_mcustall = r_cnt_mcu;
  assign cnt_except   = r_cnt_exc;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: default instance plus a CNT_W=4 instance for saturation.
module tb_hazard_ctrl_mc;
  logic        clk;
  logic        resetn;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_rmem;
  logic [1:0]  ex_mcu_req, mcu_ready;
  logic        stallreq_from_if, stallreq_from_mem;
  logic [31:0] mem_excepttype, mem_cp0_epc;
  logic        cnt_clr;

  logic [1:0]  mcu_start, mcu_cancel, mcu_start4, mcu_cancel4;
  logic [4:0]  stall, flush, stall4, flush4;
  logic [31:0] mem_newpc, mem_newpc4;
  logic        except_flush, except_flush4;
  logic [31:0] cnt_lwstall, cnt_mcustall, cnt_except;
  logic [3:0]  cnt_lwstall4, cnt_mcustall4, cnt_except4;

  int checks = 0;
  int failures = 0;

  hazard_ctrl_mc dut (
    .clk(clk), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_rmem(ex_rmem),
    .ex_mcu_req(ex_mcu_req), .mcu_ready(mcu_ready), .mcu_start(mcu_start), .mcu_cancel(mcu_cancel),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc), .stall(stall), .flush(flush),
    .mem_newpc(mem_newpc), .except_flush(except_flush), .cnt_clr(cnt_clr),
    .cnt_lwstall(cnt_lwstall), .cnt_mcustall(cnt_mcustall), .cnt_except(cnt_except)
  );

  hazard_ctrl_mc #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_rmem(ex_rmem),
    .ex_mcu_req(ex_mcu_req), .mcu_ready(mcu_ready), .mcu_start(mcu_start4), .mcu_cancel(mcu_cancel4),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc), .stall(stall4), .flush(flush4),
    .mem_newpc(mem_newpc4), .except_flush(except_flush4), .cnt_clr(cnt_clr),
    .cnt_lwstall(cnt_lwstall4), .cnt_mcustall(cnt_mcustall4), .cnt_except(cnt_except4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task test_reset();
    resetn = 1'b0; id_rs = 0; id_rt = 0; ex_rt = 0; ex_rmem = 0; ex_mcu_req = 2'b01;
    mcu_ready = 0; stallreq_from_if = 0; stallreq_from_mem = 0; mem_excepttype = 0;
    mem_cp0_epc = 0; cnt_clr = 0;
    #3;
    checks++; if (mcu_start !== 2'b00) begin failures++; $display("FAIL reset_start got=%b exp=00", mcu_start); end
    checks++; if (mcu_cancel !== 2'b00) begin failures++; $display("FAIL reset_cancel got=%b exp=00", mcu_cancel); end
    checks++; if (cnt_lwstall !== 0 || cnt_mcustall !== 0 || cnt_except !== 0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_lwstall, cnt_mcustall, cnt_except); end
    checks++; if (stall !== 5'b01111) begin failures++; $display("FAIL reset_comb_stall got=%b exp=01111", stall); end
    @(negedge clk); ex_mcu_req = 0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task test_lwstall();
    @(negedge clk); ex_rmem = 1; ex_rt = 5; id_rs = 5; id_rt = 3; #1;
    checks++; if (stall !== 5'b00011) begin failures++; $display("FAIL lw_rs_stall got=%b exp=00011", stall); end
    checks++; if (flush !== 5'b00100) begin failures++; $display("FAIL lw_rs_flush got=%b exp=00100", flush); end
    @(negedge clk); ex_rt = 0; id_rs = 0; id_rt = 0; #1;
    checks++; if (stall !== 5'b00000 || flush !== 5'b00000) begin
      failures++; $display("FAIL lw_r0 got=%b/%b exp=00000/00000", stall, flush); end
    checks++; if (cnt_lwstall !== 1) begin failures++; $display("FAIL lw_cnt1 got=%0d exp=1", cnt_lwstall); end
    @(negedge clk); ex_rt = 7; id_rs = 2; id_rt = 7; #1;
    checks++; if (stall !== 5'b00011) begin failures++; $display("FAIL lw_rt_stall got=%b exp=00011", stall); end
    @(negedge clk); ex_rmem = 0; #1;
    checks++; if (stall !== 5'b00000) begin failures++; $display("FAIL lw_noload got=%b exp=00000", stall); end
    checks++; if (cnt_lwstall !== 2) begin failures++; $display("FAIL lw_cnt2 got=%0d exp=2", cnt_lwstall); end
  endtask

  task test_mcu_handshake();
    @(negedge clk); ex_mcu_req = 2'b01; mcu_ready = 0; #1;
    checks++; if (mcu_start !== 2'b01) begin failures++; $display("FAIL hs_start got=%b exp=01", mcu_start); end
    checks++; if (stall !== 5'b01111) begin failures++; $display("FAIL hs_stall0 got=%b exp=01111", stall); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); if (k == 4) mcu_ready = 2'b01; #1;
      checks++; if (mcu_start !== 2'b00 || stall !== 5'b01111) begin
        failures++; $display("FAIL hs_busy%0d got=%b/%b exp=00/01111", k, mcu_start, stall); end
    end
    @(negedge clk); #1;
    checks++; if (stall !== 5'b00000 || mcu_start !== 2'b00) begin
      failures++; $display("FAIL hs_done got=%b/%b exp=00000/00", stall, mcu_start); end
    checks++; if (cnt_mcustall !== 5) begin failures++; $display("FAIL hs_cnt got=%0d exp=5", cnt_mcustall); end
    @(negedge clk); ex_mcu_req = 0; #1;
    checks++; if (mcu_start !== 2'b00) begin failures++; $display("FAIL hs_idle got=%b exp=00", mcu_start); end
  endtask

  task test_done_hold();
    @(negedge clk); ex_mcu_req = 2'b01; mcu_ready = 0;
    @(negedge clk); mcu_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); stallreq_from_mem = 1; #1;
      checks++; if (mcu_start !== 2'b00 || stall !== 5'b01111 || flush !== 5'b10000) begin
        failures++; $display("FAIL dh_hold%0d got=%b/%b/%b exp=00/01111/10000", k, mcu_start, stall, flush); end
    end
    @(negedge clk); stallreq_from_mem = 0; #1;
    checks++; if (mcu_start !== 2'b00 || stall !== 5'b00000) begin
      failures++; $display("FAIL dh_release got=%b/%b exp=00/00000", mcu_start, stall); end
    @(negedge clk); mcu_ready = 0; #1;
    checks++; if (mcu_start !== 2'b01) begin failures++; $display("FAIL dh_restart got=%b exp=01", mcu_start); end
  endtask

  task test_exception_cancel();
    @(negedge clk); mem_excepttype = 32'd1; mcu_ready = 2'b01; #1;
    checks++; if (mcu_cancel !== 2'b01) begin failures++; $display("FAIL ex_cancel got=%b exp=01", mcu_cancel); end
    checks++; if (flush !== 5'b11111 || stall !== 5'b00000) begin
      failures++; $display("FAIL ex_flush got=%b/%b exp=11111/00000", flush, stall); end
    checks++; if (except_flush !== 1'b1 || mem_newpc !== 32'hBFC00380) begin
      failures++; $display("FAIL ex_pc got=%b/%h exp=1/bfc00380", except_flush, mem_newpc); end
    @(negedge clk); mem_excepttype = 0; mcu_ready = 0; #1;
    checks++; if (mcu_cancel !== 2'b00 || mcu_start !== 2'b01) begin
      failures++; $display("FAIL ex_idle got=%b/%b exp=00/01", mcu_cancel, mcu_start); end
    checks++; if (cnt_except !== 1) begin failures++; $display("FAIL ex_cnt got=%0d exp=1", cnt_except); end
    @(negedge clk); mcu_ready = 2'b01;
    @(negedge clk); ex_mcu_req = 0;
    @(negedge clk); mcu_ready = 0;
  endtask

  task test_eret_wait();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mem_excepttype = 32'h0E; mem_cp0_epc = 32'h80001234; stallreq_from_if = 1; #1;
      checks++; if (except_flush !== 1'b0 || flush !== 5'b10000 || stall !== 5'b01111) begin
        failures++; $display("FAIL eret_wait%0d got=%b/%b/%b exp=0/10000/01111", k, except_flush, flush, stall); end
    end
    @(negedge clk); stallreq_from_if = 0; #1;
    checks++; if (except_flush !== 1'b1 || flush !== 5'b11111 || mem_newpc !== 32'h80001234) begin
      failures++; $display("FAIL eret_take got=%b/%b/%h exp=1/11111/80001234", except_flush, flush, mem_newpc); end
    @(negedge clk); mem_excepttype = 0; #1;
    checks++; if (cnt_except !== 2 || mem_newpc !== 32'hBFC00380) begin
      failures++; $display("FAIL eret_after got=%0d/%h exp=2/bfc00380", cnt_except, mem_newpc); end
  endtask

  task test_saturation();
    @(negedge clk); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0; #1;
    checks++; if (cnt_lwstall4 !== 4'd0 || cnt_except !== 0) begin
      failures++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", cnt_lwstall4, cnt_except); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); ex_rmem = 1; ex_rt = 9; id_rs = 9; id_rt = 0;
    end
    @(negedge clk); ex_rmem = 0; #1;
    checks++; if (cnt_lwstall4 !== 4'd15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt_lwstall4); end
    checks++; if (cnt_lwstall !== 20) begin failures++; $display("FAIL sat_cnt32 got=%0d exp=20", cnt_lwstall); end
    @(negedge clk); ex_rmem = 1; cnt_clr = 1;
    @(negedge clk); ex_rmem = 0; cnt_clr = 0; #1;
    checks++; if (cnt_lwstall4 !== 4'd0 || cnt_lwstall !== 0) begin
      failures++; $display("FAIL sat_clr_wins got=%0d/%0d exp=0/0", cnt_lwstall4, cnt_lwstall); end
  endtask

  task test_reset_mid_busy();
    @(negedge clk); ex_mcu_req = 2'b01; mcu_ready = 0;
    @(negedge clk); #1;
    checks++; if (mcu_start !== 2'b00 || cnt_mcustall === 0) begin
      failures++; $display("FAIL rb_busy got=%b/%0d exp=00/nonzero", mcu_start, cnt_mcustall); end
    #1 resetn = 1'b0; #1;
    checks++; if (mcu_cancel !== 2'b00 || mcu_start !== 2'b00 || cnt_mcustall !== 0) begin
      failures++; $display("FAIL rb_async got=%b/%b/%0d exp=00/00/0", mcu_cancel, mcu_start, cnt_mcustall); end
    @(negedge clk); resetn = 1'b1; #1;
    checks++; if (mcu_start !== 2'b01) begin failures++; $display("FAIL rb_idle got=%b exp=01", mcu_start); end
    @(negedge clk); mcu_ready = 2'b01;
    @(negedge clk); ex_mcu_req = 0;
    @(negedge clk); mcu_ready = 0;
  endtask

  initial begin
    test_reset();
    test_lwstall();
    test_mcu_handshake();
    test_done_hold();
    test_exception_cancel();
    test_eret_wait();
    test_saturation();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
